// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline-register chain.
package pipe_pkg;

  localparam int unsigned PIPE_WIDTH    = 32;
  localparam int unsigned PIPE_REG_BITS = 5;
  localparam int unsigned FWD_RF        = 0;

  // Forward-select width: one code for the register file plus one per stage.
  function automatic int unsigned fwd_sel_width(input int unsigned depth);
    return 32'($clog2(depth + 1));
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [PIPE_WIDTH-1:0]    payload;
    logic [PIPE_REG_BITS-1:0] dest;
    logic                     regwrite;
    logic                     memread;
  } stage_entry_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline entry register: bubble insertion and optional load-data capture.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH   = PIPE_WIDTH,
  parameter type         entry_t = stage_entry_t
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             bubble_i,
  input  logic             capture_en_i,
  input  entry_t           entry_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output entry_t           entry_o
);

  entry_t entry_d;
  entry_t entry_q;

  // A valid load entering the capture stage swaps its payload for memory data.
  always_comb begin
    entry_d = entry_i;
    if (bubble_i) begin
      entry_d = '0;
    end else if (capture_en_i && entry_i.valid && entry_i.memread) begin
      entry_d.payload = mem_rdata_i;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with flush bubbles, load-use stall
// detection and youngest-first operand forwarding.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned REG_BITS = 5,
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic                             Clk,
  input  logic                             Reset_n,
  input  logic                             in_valid,
  input  logic [WIDTH-1:0]                 in_payload,
  input  logic [REG_BITS-1:0]              in_dest,
  input  logic                             in_regwrite,
  input  logic                             in_memread,
  input  logic [REG_BITS-1:0]              in_rs,
  input  logic [REG_BITS-1:0]              in_rt,
  input  logic                             in_flush,
  input  logic [WIDTH-1:0]                 mem_rdata,
  output logic                             in_ready,
  output logic [fwd_sel_width(DEPTH)-1:0]  fwd_sel_a,
  output logic [fwd_sel_width(DEPTH)-1:0]  fwd_sel_b,
  output logic [WIDTH-1:0]                 fwd_data_a,
  output logic [WIDTH-1:0]                 fwd_data_b,
  output logic                             out_valid,
  output logic                             out_regwrite,
  output logic [REG_BITS-1:0]              out_dest,
  output logic [WIDTH-1:0]                 out_payload
);

  localparam int unsigned SEL_W = fwd_sel_width(DEPTH);

  typedef struct packed {
    logic                valid;
    logic [WIDTH-1:0]    payload;
    logic [REG_BITS-1:0] dest;
    logic                regwrite;
    logic                memread;
  } entry_t;

  entry_t stage_q  [DEPTH];
  entry_t stage_in [DEPTH];
  logic   unready_a;
  logic   unready_b;
  logic   load_use_stall;
  logic   issue_bubble;

  function automatic logic src_hit(input entry_t e, input logic [REG_BITS-1:0] r);
    return e.valid && e.regwrite && (e.dest == r) && (r != '0);
  endfunction

  // Scan oldest to youngest so the youngest matching stage is left standing.
  always_comb begin
    fwd_sel_a  = SEL_W'(FWD_RF);
    fwd_sel_b  = SEL_W'(FWD_RF);
    fwd_data_a = '0;
    fwd_data_b = '0;
    unready_a  = 1'b0;
    unready_b  = 1'b0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (src_hit(stage_q[k], in_rs)) begin
        fwd_sel_a  = SEL_W'(k + 1);
        fwd_data_a = stage_q[k].payload;
        unready_a  = (k < int'(LOAD_LAT)) && stage_q[k].memread;
      end
      if (src_hit(stage_q[k], in_rt)) begin
        fwd_sel_b  = SEL_W'(k + 1);
        fwd_data_b = stage_q[k].payload;
        unready_b  = (k < int'(LOAD_LAT)) && stage_q[k].memread;
      end
    end
  end

  assign load_use_stall = in_valid && !in_flush && (unready_a || unready_b);
  assign in_ready       = !load_use_stall;
  assign issue_bubble   = in_flush || load_use_stall || !in_valid;

  always_comb begin
    stage_in[0] = '{valid:    1'b1,
                    payload:  in_payload,
                    dest:     in_dest,
                    regwrite: in_regwrite,
                    memread:  in_memread};
    for (int k = 1; k < int'(DEPTH); k++) begin
      stage_in[k] = stage_q[k-1];
    end
  end

  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    pipe_stage #(
      .WIDTH   (WIDTH),
      .entry_t (entry_t)
    ) u_stage (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .bubble_i     ((k == 0) && issue_bubble),
      .capture_en_i (32'(k) == LOAD_LAT),
      .entry_i      (stage_in[k]),
      .mem_rdata_i  (mem_rdata),
      .entry_o      (stage_q[k])
    );
  end

  assign out_valid    = stage_q[DEPTH-1].valid;
  assign out_regwrite = stage_q[DEPTH-1].valid && stage_q[DEPTH-1].regwrite;
  assign out_dest     = stage_q[DEPTH-1].dest;
  assign out_payload  = stage_q[DEPTH-1].payload;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: directed hazard scenarios plus random traffic
// against an age-indexed reference model of the in-flight instructions.
module tb_pipe_stage_chain;

  localparam int WIDTH    = 32;
  localparam int DEPTH    = 3;
  localparam int REG_BITS = 5;
  localparam int LOAD_LAT = 1;
  localparam int SEL_W    = $clog2(DEPTH + 1);

  logic                Clk;
  logic                Reset_n;
  logic                in_valid;
  logic [WIDTH-1:0]    in_payload;
  logic [REG_BITS-1:0] in_dest;
  logic                in_regwrite;
  logic                in_memread;
  logic [REG_BITS-1:0] in_rs;
  logic [REG_BITS-1:0] in_rt;
  logic                in_flush;
  logic [WIDTH-1:0]    mem_rdata;
  logic                in_ready;
  logic [SEL_W-1:0]    fwd_sel_a;
  logic [SEL_W-1:0]    fwd_sel_b;
  logic [WIDTH-1:0]    fwd_data_a;
  logic [WIDTH-1:0]    fwd_data_b;
  logic                out_valid;
  logic                out_regwrite;
  logic [REG_BITS-1:0] out_dest;
  logic [WIDTH-1:0]    out_payload;

  pipe_stage_chain #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .REG_BITS(REG_BITS), .LOAD_LAT(LOAD_LAT)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .in_valid(in_valid), .in_payload(in_payload),
    .in_dest(in_dest), .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_rs(in_rs), .in_rt(in_rt), .in_flush(in_flush), .mem_rdata(mem_rdata),
    .in_ready(in_ready), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b), .out_valid(out_valid),
    .out_regwrite(out_regwrite), .out_dest(out_dest), .out_payload(out_payload)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Model: index = age in cycles since issue (0 = youngest).
  logic                m_v  [DEPTH];
  logic [WIDTH-1:0]    m_p  [DEPTH];
  logic [REG_BITS-1:0] m_d  [DEPTH];
  logic                m_rw [DEPTH];
  logic                m_mr [DEPTH];

  int checks   = 0;
  int failures = 0;
  bit last_stall = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < DEPTH; k++) begin
      m_v[k] = 1'b0; m_p[k] = '0; m_d[k] = '0; m_rw[k] = 1'b0; m_mr[k] = 1'b0;
    end
  endtask

  // Youngest in-flight writer of r; a load younger than LOAD_LAT has no data yet.
  task automatic model_src(input logic [REG_BITS-1:0] r, output int sel,
                           output logic [WIDTH-1:0] data, output bit unready);
    sel = 0; data = '0; unready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (sel == 0 && m_v[k] && m_rw[k] && m_d[k] == r && r != 0) begin
        sel     = k + 1;
        data    = m_p[k];
        unready = (k < LOAD_LAT) && m_mr[k];
      end
    end
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] p, input logic [REG_BITS-1:0] d,
                       input bit rw, input bit mr, input logic [REG_BITS-1:0] rs,
                       input logic [REG_BITS-1:0] rt, input bit fl);
    in_valid = v; in_payload = p; in_dest = d; in_regwrite = rw;
    in_memread = mr; in_rs = rs; in_rt = rt; in_flush = fl;
  endtask

  // One clock: check outputs at the falling edge, then age the model.
  task automatic step();
    int sa, sb;
    logic [WIDTH-1:0] da, db;
    bit ua, ub, stall, bub;
    model_src(in_rs, sa, da, ua);
    model_src(in_rt, sb, db, ub);
    stall = in_valid && !in_flush && (ua || ub);
    @(negedge Clk);
    chk("in_ready", 64'(in_ready), 64'(!stall));
    if (!stall) begin
      chk("fwd_sel_a", 64'(fwd_sel_a), 64'(sa));
      chk("fwd_data_a", 64'(fwd_data_a), 64'(da));
      chk("fwd_sel_b", 64'(fwd_sel_b), 64'(sb));
      chk("fwd_data_b", 64'(fwd_data_b), 64'(db));
    end
    chk("out_valid", 64'(out_valid), 64'(m_v[DEPTH-1]));
    chk("out_regwrite", 64'(out_regwrite), 64'(m_v[DEPTH-1] && m_rw[DEPTH-1]));
    chk("out_dest", 64'(out_dest), 64'(m_d[DEPTH-1]));
    chk("out_payload", 64'(out_payload), 64'(m_p[DEPTH-1]));
    last_stall = stall;
    bub = !in_valid || in_flush || stall;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      m_p[k]  = (k == LOAD_LAT && m_v[k-1] && m_mr[k-1]) ? mem_rdata : m_p[k-1];
      m_v[k]  = m_v[k-1];
      m_d[k]  = m_d[k-1];
      m_rw[k] = m_rw[k-1];
      m_mr[k] = m_mr[k-1];
    end
    m_v[0]  = !bub;
    m_p[0]  = bub ? '0 : in_payload;
    m_d[0]  = bub ? '0 : in_dest;
    m_rw[0] = bub ? 1'b0 : in_regwrite;
    m_mr[0] = bub ? 1'b0 : in_memread;
    @(posedge Clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_out_regwrite"}, 64'(out_regwrite), 64'(0));
    chk({tag, "_out_payload"}, 64'(out_payload), 64'(0));
    chk({tag, "_fwd_sel_a"}, 64'(fwd_sel_a), 64'(0));
    chk({tag, "_fwd_sel_b"}, 64'(fwd_sel_b), 64'(0));
    chk({tag, "_fwd_data_a"}, 64'(fwd_data_a), 64'(0));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
  endtask

  // Asynchronous assert mid-cycle, release away from the rising edge.
  task automatic mid_reset(input string tag);
    Reset_n = 1'b0;
    #1;
    reset_checks(tag);
    clear_model();
    in_valid = 1'b0;
    in_flush = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0;
    drive(0, '0, '0, 0, 0, '0, '0, 0);
    mem_rdata = '0;
    clear_model();
    repeat (2) @(posedge Clk);
    #1;
    reset_checks("por");
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    // Back-to-back dependency forwards from stage 0.
    drive(1, 32'h11, 3, 1, 0, 1, 2, 0); step();
    drive(1, 32'h05, 6, 1, 0, 3, 5, 0); #2;
    chk("dep_sel_a", 64'(fwd_sel_a), 64'(1));
    chk("dep_data_a", 64'(fwd_data_a), 64'h11);
    chk("dep_ready", 64'(in_ready), 64'(1));
    step();

    // Two writers of $3 in flight: youngest wins.
    drive(1, 32'h33, 3, 1, 0, 0, 0, 0); step();
    drive(1, 32'h44, 7, 1, 0, 0, 0, 0); step();
    drive(1, 32'h22, 3, 1, 0, 0, 0, 0); step();
    drive(1, 32'h01, 8, 1, 0, 3, 3, 0); #2;
    chk("young_sel_a", 64'(fwd_sel_a), 64'(1));
    chk("young_data_a", 64'(fwd_data_a), 64'h22);
    chk("young_sel_b", 64'(fwd_sel_b), 64'(1));
    step();

    // Load-use: one stall cycle, then forwarding of the loaded data.
    drive(1, 32'h99, 4, 1, 1, 0, 0, 0); step();
    drive(1, 32'h05, 9, 1, 0, 4, 0, 0);
    mem_rdata = 32'hDEAD; #2;
    chk("lu_stall", 64'(in_ready), 64'(0));
    step();
    mem_rdata = 32'h0; #2;
    chk("lu_release", 64'(in_ready), 64'(1));
    chk("lu_sel_a", 64'(fwd_sel_a), 64'(2));
    chk("lu_data_a", 64'(fwd_data_a), 64'hDEAD);
    step();

    // Flush beats a pending load-use stall; the slot retires as a bubble.
    drive(1, 32'hAA, 5, 1, 1, 0, 0, 0); step();
    drive(1, 32'h77, 6, 1, 0, 5, 0, 1); #2;
    chk("flush_ready", 64'(in_ready), 64'(1));
    step();
    drive(1, 32'h12, 8, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) step();
    chk("flush_slot_valid", 64'(out_valid), 64'(0));

    // Writes to $0 never forward.
    drive(1, 32'h55, 0, 1, 0, 0, 0, 0); step();
    drive(1, 32'h66, 9, 1, 0, 0, 0, 0); #2;
    chk("r0_sel_a", 64'(fwd_sel_a), 64'(0));
    chk("r0_sel_b", 64'(fwd_sel_b), 64'(0));
    chk("r0_ready", 64'(in_ready), 64'(1));
    step();

    // Reset with a full chain of valid writers.
    drive(1, 32'hA0, 10, 1, 0, 0, 0, 0); step();
    drive(1, 32'hA1, 11, 1, 0, 0, 0, 0); step();
    drive(1, 32'hA2, 12, 1, 0, 0, 0, 0); step();
    drive(1, 32'hA3, 13, 1, 0, 10, 12, 0); #1;
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    mid_reset("mid_rst");
    step();

    // Random traffic on a small register set; stalled instructions are held.
    for (int n = 0; n < 1500; n++) begin
      if (!last_stall) begin
        drive(($urandom % 10) < 8, $urandom, REG_BITS'($urandom % 4),
              ($urandom % 10) < 7, ($urandom % 10) < 3,
              REG_BITS'($urandom % 4), REG_BITS'($urandom % 4),
              ($urandom % 10) == 0);
      end
      mem_rdata = $urandom;
      if (n == 750) begin
        mid_reset("rnd_rst");
        last_stall = 1'b0;
      end else begin
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
